uart_transmitter: RTL and testbench

Serial transmit stage of the SoC: accepts bytes from the CPU-side UART register (`tx_send`/`tx_data`) into a small FIFO and shifts them out on the `uart_tx` pin as 8N1 frames at a fixed baud rate. It sits directly between the SoC's memory-mapped UART write path and the board pin. The testbench echo monitor observes its input handshake; the physical line is its output.

---
 rtl/uart_transmitter_if.sv | 16 +
 rtl/uart_transmitter.sv | 183 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if
// Byte handshake between the CPU-side UART register and the transmitter.
//   tx_send  : byte-valid strobe, one cycle per byte (CPU -> transmitter)
//   tx_data  : byte to send, taken when tx_send && tx_ready
//   tx_ready : FIFO has room (transmitter -> CPU)
//   tx_idle  : FIFO empty and no frame on the line (transmitter -> CPU)
`timescale 1ns/1ps
interface uart_transmitter_if;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_idle;

    modport master (output tx_send, output tx_data, input tx_ready, input tx_idle);
    modport slave  (input tx_send, input tx_data, output tx_ready, output tx_idle);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter
// Buffers bytes from the CPU in a small FIFO and shifts them out as 8N1
// frames (start, 8 data LSB first, stop) at a fixed baud rate.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | start bit (line low) for one bit time
// DATA   | eight data bits, LSB first, one bit time each
// STOP   | stop bit (line high); chains straight into the next START
//
// Ports:
//   clk     : system clock, rising edge
//   resetn  : asynchronous active-low reset
//   bus     : byte handshake (tx_send/tx_data in, tx_ready/tx_idle out)
//   uart_tx : serial line, idle high, driven from a flop
`timescale 1ns/1ps
module uart_transmitter #(
    parameter int CLK_MHZ    = 1,
    parameter int BAUD       = 125000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    uart_transmitter_if.slave bus,
    output logic              uart_tx
);

    localparam int CLKS_PER_BIT = (CLK_MHZ * 1000000) / BAUD;
    localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PTR_W        = AW + 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_transmitter: CLKS_PER_BIT must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_transmitter: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [7:0]       fifo_head;

    state_t           state;
    state_t           state_nxt;
    logic [BW-1:0]    baud_cnt;
    logic [BW-1:0]    baud_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nxt;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_nxt;
    logic             line_nxt;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle does not make room for a push into a full FIFO.
    assign push       = bus.tx_send && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    assign bus.tx_ready = !fifo_full;
    assign bus.tx_idle  = (state == S_IDLE) && fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            shift_reg <= shift_nxt;
            uart_tx   <= line_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift_reg;
        pop       = 1'b0;
        line_nxt  = 1'b1;

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_head;
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_cnt == '0) begin
                    baud_nxt  = BAUD_RELOAD;
                    bit_nxt   = 3'd0;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_cnt == '0) begin
                    baud_nxt  = BAUD_RELOAD;
                    shift_nxt = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_cnt == '0) begin
                    // Chaining into the next start bit here gives zero idle gap.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_head;
                        baud_nxt  = BAUD_RELOAD;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // The line flop is loaded with the level of the state being entered,
        // so each bit appears on the pin in the same cycle its state begins.
        case (state_nxt)
            S_START: line_nxt = 1'b0;
            S_DATA:  line_nxt = shift_nxt[0];
            default: line_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
module tb_uart_transmitter;

    logic clk;
    logic resetn;
    logic uart_tx;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   rx_ferr;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    uart_transmitter_if u_if ();

    uart_transmitter #(
        .CLK_MHZ   (1),
        .BAUD      (125000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if),
        .uart_tx(uart_tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference 8-clk/bit receiver: samples mid-bit on falling clock edges.
    initial begin : rx_mon
        logic [7:0] b;
        logic       ab;
        int         st;
        rx_ferr = 0;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && uart_tx === 1'b0) begin
                st = cyc;
                ab = 1'b0;
                b  = '0;
                repeat (4) begin
                    @(negedge clk);
                    if (resetn !== 1'b1) ab = 1'b1;
                end
                if (!ab && uart_tx !== 1'b0) rx_ferr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (8) begin
                        @(negedge clk);
                        if (resetn !== 1'b1) ab = 1'b1;
                    end
                    b[i] = uart_tx;
                end
                repeat (8) begin
                    @(negedge clk);
                    if (resetn !== 1'b1) ab = 1'b1;
                end
                if (!ab) begin
                    if (uart_tx !== 1'b1) rx_ferr++;
                    rx_q.push_back(b);
                    rx_t.push_back(st);
                end
            end
        end
    end

    task automatic wait_idle(input string name, input int bound);
        int t;
        t = 0;
        while (u_if.tx_idle !== 1'b1 && t < bound) begin
            @(negedge clk);
            t++;
        end
        check(name, u_if.tx_idle, 1'b1);
    endtask

    task automatic wait_cyc(input string name, input int target);
        int t;
        t = 0;
        while (cyc < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(name, cyc, target);
    endtask

    // Sends one byte from an idle DUT and checks every bit period of its frame.
    task automatic run_frame(input logic [7:0] d, input logic [9:0] fr, input string tag);
        logic ok;
        rx_q.delete();
        rx_t.delete();
        u_if.tx_send = 1'b1;
        u_if.tx_data = d;
        @(posedge clk);
        #1 u_if.tx_send = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after_accept"}, u_if.tx_idle, 1'b0);
        check({tag, "_line_before_pop"}, uart_tx, 1'b1);
        @(posedge clk);
        for (int bi = 0; bi < 10; bi++) begin
            ok = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (uart_tx !== fr[bi]) ok = 1'b0;
            end
            check($sformatf("%s_bit%0d", tag, bi), ok, 1'b1);
        end
        check({tag, "_idle_in_stop"}, u_if.tx_idle, 1'b0);
        @(negedge clk);
        check({tag, "_idle_at_80"}, u_if.tx_idle, 1'b1);
        check({tag, "_rx_count"}, rx_q.size(), 1);
        if (rx_q.size() == 1) check({tag, "_rx_byte"}, rx_q[0], d);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[7];
    logic burst_rdy[5];

    initial begin : main
        logic ok;
        int   c1;
        int   t;
        logic [7:0] exp_q[$];

        n_checks = 0;
        n_errors = 0;

        // frame bit i is the level during bit period i: start, d0..d7, stop
        vecs[0] = '{data: 8'h41, frame: 10'h282};
        vecs[1] = '{data: 8'h00, frame: 10'h200};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'hA5, frame: 10'h34A};
        vecs[4] = '{data: 8'h55, frame: 10'h2AA};
        vecs[5] = '{data: 8'h80, frame: 10'h300};
        vecs[6] = '{data: 8'h01, frame: 10'h202};
        for (int i = 0; i < 5; i++) burst_rdy[i] = 1'b1;

        resetn       = 1'b0;
        u_if.tx_send = 1'b0;
        u_if.tx_data = 8'h00;

        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || u_if.tx_ready !== 1'b1 || u_if.tx_idle !== 1'b1) ok = 1'b0;
        end
        check("reset_hold", ok, 1'b1);
        resetn = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || u_if.tx_ready !== 1'b1 || u_if.tx_idle !== 1'b1) ok = 1'b0;
        end
        check("post_reset_quiet", ok, 1'b1);

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].data, vecs[v].frame, $sformatf("vec%0d", v));
        end

        // Burst of five plus overflow attempts with 0xFF.
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        c1 = 0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("burst_ready%0d", i), u_if.tx_ready, burst_rdy[i]);
            if (u_if.tx_ready === 1'b1) exp_q.push_back(8'(i));
            u_if.tx_send = 1'b1;
            u_if.tx_data = 8'(i);
            @(posedge clk);
            @(negedge clk);
            if (i == 0) c1 = cyc;
        end
        for (int j = 0; j < 3; j++) begin
            check($sformatf("ovf_ready%0d", j), u_if.tx_ready, 1'b0);
            u_if.tx_send = 1'b1;
            u_if.tx_data = 8'hFF;
            @(posedge clk);
            @(negedge clk);
        end
        u_if.tx_send = 1'b0;
        wait_cyc("burst_wait_pop", c1 + 80);
        check("ready_before_pop", u_if.tx_ready, 1'b0);
        @(negedge clk);
        check("ready_after_pop", u_if.tx_ready, 1'b1);
        wait_idle("burst_idle", 600);
        check("burst_rx_count", rx_q.size(), exp_q.size());
        if (rx_q.size() == 5 && exp_q.size() == 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("burst_byte%0d", i), rx_q[i], exp_q[i]);
            for (int i = 1; i < 5; i++) check($sformatf("burst_gap%0d", i), rx_t[i] - rx_t[i-1], 80);
            check("burst_total", cyc - rx_t[0], 400);
        end

        // Reset during data bit 3 of 0x55 with two bytes queued behind it.
        @(negedge clk);
        rx_q.delete();
        rx_t.delete();
        u_if.tx_send = 1'b1;
        u_if.tx_data = 8'h55;
        @(posedge clk);
        @(negedge clk);
        c1 = cyc;
        u_if.tx_data = 8'h12;
        @(posedge clk);
        @(negedge clk);
        u_if.tx_data = 8'h34;
        @(posedge clk);
        @(negedge clk);
        u_if.tx_send = 1'b0;
        wait_cyc("mid_wait", c1 + 37);
        check("mid_bit3_level", uart_tx, 1'b0);
        check("mid_busy", u_if.tx_idle, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("mid_reset_line", uart_tx, 1'b1);
        check("mid_reset_ready", u_if.tx_ready, 1'b1);
        check("mid_reset_idle", u_if.tx_idle, 1'b1);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || u_if.tx_idle !== 1'b1) ok = 1'b0;
        end
        check("mid_quiet_after", ok, 1'b1);
        check("mid_rx_none", rx_q.size(), 0);

        // Random loopback.
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        for (int n = 0; n < 256; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            t = 0;
            while (u_if.tx_ready !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                check("loop_ready_timeout", u_if.tx_ready, 1'b1);
                break;
            end
            u_if.tx_send = 1'b1;
            u_if.tx_data = 8'($urandom_range(0, 255));
            exp_q.push_back(u_if.tx_data);
            @(posedge clk);
            @(negedge clk);
            u_if.tx_send = 1'b0;
        end
        wait_idle("loop_idle", 1000);
        repeat (2) @(negedge clk);
        check("loop_rx_count", rx_q.size(), 256);
        for (int i = 0; i < 256; i++) begin
            if (i < rx_q.size() && i < exp_q.size())
                check($sformatf("loop_byte%0d", i), rx_q[i], exp_q[i]);
        end
        check("framing_errors", rx_ferr, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
